// File: rtl/acc_cpu_ctrl.sv
// Six-phase fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Drives the bus and load strobes of the datapath from the T-state and the latched opcode.
module acc_cpu_ctrl #(
  parameter int OP_W = 4,
  parameter bit STEP = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [OP_W-1:0] op_i,
  output logic            cp_o,
  output logic            ep_o,
  output logic            im_o,
  output logic            er_o,
  output logic            ii_o,
  output logic            ei_o,
  output logic            ia_o,
  output logic            ea_o,
  output logic            ib_o,
  output logic            su_o,
  output logic            eu_o,
  output logic            io_o,
  output logic [2:0]      tstate_o,
  output logic            halted_o
);

  localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'h0);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'h2);
  localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'hE);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'hF);

  // Encoding equals the externally visible tstate value.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: if (start_i) state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3:   state_d = S_T4;
      S_T4: begin
        op_d    = op_i;
        state_d = (op_i == OP_HLT) ? S_HALT : S_T5;
      end
      S_T5:   state_d = S_T6;
      S_T6:   state_d = STEP ? S_IDLE : S_T1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode only flopped state (plus the IR opcode, stable since T3 ended),
  // so reset forces them idle without waiting for a clock.
  always_comb begin
    cp_o = 1'b0;
    ep_o = 1'b1;
    im_o = 1'b1;
    er_o = 1'b1;
    ii_o = 1'b1;
    ei_o = 1'b1;
    ia_o = 1'b1;
    ea_o = 1'b1;
    ib_o = 1'b1;
    su_o = 1'b0;
    eu_o = 1'b1;
    io_o = 1'b1;
    unique case (state_q)
      S_T1: begin
        ep_o = 1'b0;
        im_o = 1'b0;
      end
      S_T2: cp_o = 1'b1;
      S_T3: begin
        er_o = 1'b0;
        ii_o = 1'b0;
      end
      S_T4: begin
        if (op_i == OP_LDA || op_i == OP_ADD || op_i == OP_SUB) begin
          ei_o = 1'b0;
          im_o = 1'b0;
        end else if (op_i == OP_OUT) begin
          ea_o = 1'b0;
          io_o = 1'b0;
        end
      end
      S_T5: begin
        if (op_q == OP_LDA) begin
          er_o = 1'b0;
          ia_o = 1'b0;
        end else if (op_q == OP_ADD || op_q == OP_SUB) begin
          er_o = 1'b0;
          ib_o = 1'b0;
        end
      end
      S_T6: begin
        if (op_q == OP_ADD || op_q == OP_SUB) begin
          eu_o = 1'b0;
          ia_o = 1'b0;
          su_o = (op_q == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  assign tstate_o = state_q;
  assign halted_o = (state_q == S_HALT);

endmodule

// File: tb/tb_acc_cpu_ctrl.sv
// Bench for acc_cpu_ctrl: one free-running and one single-step instance, a phase-level
// reference model, a table of per-opcode strobe sequences and directed corner sequences.
module tb_acc_cpu_ctrl;

  localparam int M_CP = 11, M_EP = 10, M_IM = 9, M_ER = 8, M_II = 7, M_EI = 6;
  localparam int M_IA = 5, M_EA = 4, M_IB = 3, M_SU = 2, M_EU = 1, M_IO = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_v [2];
  logic [3:0] op_v    [2];

  logic        cp [2], ep [2], im [2], er [2], ii [2], ei [2];
  logic        ia [2], ea [2], ib [2], su [2], eu [2], io [2];
  logic [2:0]  ts [2];
  logic        hl [2];
  logic [11:0] act [2];

  int nvec = 0;
  int errs = 0;

  int         m_phase [2];
  logic [3:0] m_opq   [2];

  always #5 clk = ~clk;

  acc_cpu_ctrl #(.OP_W(4), .STEP(1'b0)) dut_run (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[0]), .op_i(op_v[0]),
    .cp_o(cp[0]), .ep_o(ep[0]), .im_o(im[0]), .er_o(er[0]), .ii_o(ii[0]), .ei_o(ei[0]),
    .ia_o(ia[0]), .ea_o(ea[0]), .ib_o(ib[0]), .su_o(su[0]), .eu_o(eu[0]), .io_o(io[0]),
    .tstate_o(ts[0]), .halted_o(hl[0])
  );

  acc_cpu_ctrl #(.OP_W(4), .STEP(1'b1)) dut_step (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[1]), .op_i(op_v[1]),
    .cp_o(cp[1]), .ep_o(ep[1]), .im_o(im[1]), .er_o(er[1]), .ii_o(ii[1]), .ei_o(ei[1]),
    .ia_o(ia[1]), .ea_o(ea[1]), .ib_o(ib[1]), .su_o(su[1]), .eu_o(eu[1]), .io_o(io[1]),
    .tstate_o(ts[1]), .halted_o(hl[1])
  );

  // Active-set view: bit = 1 means the strobe is asserted, whatever its polarity.
  always_comb begin
    for (int k = 0; k < 2; k++)
      act[k] = {cp[k], ~ep[k], ~im[k], ~er[k], ~ii[k], ~ei[k],
                ~ia[k], ~ea[k], ~ib[k], su[k], ~eu[k], ~io[k]};
  end

  typedef struct {
    logic [3:0]        op;
    logic [5:0][11:0]  m;
  } vec_t;
  vec_t tbl [5];

  function automatic logic [11:0] bitm(input int b);
    logic [11:0] r;
    r = '0;
    r[b] = 1'b1;
    return r;
  endfunction

  function automatic logic [11:0] exp_mask(input int ph, input logic [3:0] o);
    logic [11:0] r;
    r = '0;
    if (ph == 1) r = bitm(M_EP) | bitm(M_IM);
    if (ph == 2) r = bitm(M_CP);
    if (ph == 3) r = bitm(M_ER) | bitm(M_II);
    if (ph == 4 && o <= 4'h2) r = bitm(M_EI) | bitm(M_IM);
    if (ph == 4 && o == 4'hE) r = bitm(M_EA) | bitm(M_IO);
    if (ph == 5 && o == 4'h0) r = bitm(M_ER) | bitm(M_IA);
    if (ph == 5 && (o == 4'h1 || o == 4'h2)) r = bitm(M_ER) | bitm(M_IB);
    if (ph == 6 && (o == 4'h1 || o == 4'h2)) r = bitm(M_EU) | bitm(M_IA);
    if (ph == 6 && o == 4'h2) r = r | bitm(M_SU);
    return r;
  endfunction

  task automatic cmp(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, k, got, want, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [3:0] o;
      o = (m_phase[k] == 4) ? op_v[k] : m_opq[k];
      cmp("strobes", k, 32'(act[k]), 32'(exp_mask(m_phase[k], o)));
      cmp("tstate", k, 32'(ts[k]), 32'(m_phase[k]));
      cmp("halted", k, 32'(hl[k]), 32'(m_phase[k] == 7));
      cmp("bus_excl", k,
          32'($countones({act[k][M_EP], act[k][M_ER], act[k][M_EI], act[k][M_EA], act[k][M_EU]}) <= 1), 32'd1);
      cmp("su_with_eu", k, 32'(!act[k][M_SU] || act[k][M_EU]), 32'd1);
    end
  endtask

  task automatic tick();
    int         nph  [2];
    logic [3:0] nopq [2];
    for (int k = 0; k < 2; k++) begin
      nph[k]  = m_phase[k];
      nopq[k] = m_opq[k];
      if (!rst_n) nph[k] = 0;
      else if (m_phase[k] == 0) nph[k] = start_v[k] ? 1 : 0;
      else if (m_phase[k] <= 3 || m_phase[k] == 5) nph[k] = m_phase[k] + 1;
      else if (m_phase[k] == 4) begin
        nopq[k] = op_v[k];
        nph[k]  = (op_v[k] == 4'hF) ? 7 : 5;
      end
      else if (m_phase[k] == 6) nph[k] = (k == 1) ? 0 : 1;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = nph[k];
      m_opq[k]   = nopq[k];
    end
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_phase[0] = 0;
    m_phase[1] = 0;
    check_all();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] fetch [3];
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    op_v[0] = 4'h0;    op_v[1] = 4'h0;
    m_phase[0] = 0;    m_phase[1] = 0;
    m_opq[0] = 4'h0;   m_opq[1] = 4'h0;

    fetch[0] = bitm(M_EP) | bitm(M_IM);
    fetch[1] = bitm(M_CP);
    fetch[2] = bitm(M_ER) | bitm(M_II);
    tbl[0].op = 4'h0; tbl[1].op = 4'h1; tbl[2].op = 4'h2; tbl[3].op = 4'hE; tbl[4].op = 4'h5;
    for (int i = 0; i < 5; i++)
      for (int t = 0; t < 3; t++) tbl[i].m[t] = fetch[t];
    tbl[0].m[3] = bitm(M_EI) | bitm(M_IM);
    tbl[0].m[4] = bitm(M_ER) | bitm(M_IA);
    tbl[0].m[5] = '0;
    tbl[1].m[3] = bitm(M_EI) | bitm(M_IM);
    tbl[1].m[4] = bitm(M_ER) | bitm(M_IB);
    tbl[1].m[5] = bitm(M_EU) | bitm(M_IA);
    tbl[2].m[3] = bitm(M_EI) | bitm(M_IM);
    tbl[2].m[4] = bitm(M_ER) | bitm(M_IB);
    tbl[2].m[5] = bitm(M_SU) | bitm(M_EU) | bitm(M_IA);
    tbl[3].m[3] = bitm(M_EA) | bitm(M_IO);
    tbl[3].m[4] = '0;
    tbl[3].m[5] = '0;
    tbl[4].m[3] = '0;
    tbl[4].m[4] = '0;
    tbl[4].m[5] = '0;

    do_reset();
    tick();
    cmp("idle_after_reset", 0, 32'(ts[0]), 32'd0);

    // Reset asserted mid-T3 must clear outputs at once and stay idle afterwards.
    op_v[0] = 4'h1; op_v[1] = 4'h1;
    start_v[0] = 1'b1; start_v[1] = 1'b1;
    tick();
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    tick();
    tick();
    cmp("in_t3", 0, 32'(ts[0]), 32'd3);
    rst_n = 1'b0;
    #1;
    m_phase[0] = 0; m_phase[1] = 0;
    cmp("async_rst_ts", 0, 32'(ts[0]), 32'd0);
    cmp("async_rst_strobes", 0, 32'(act[0]), 32'd0);
    check_all();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    cmp("idle_no_start", 0, 32'(ts[0]), 32'd0);

    // Per-opcode strobe sequences on the free-running instance.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      op_v[0] = tbl[i].op; op_v[1] = tbl[i].op;
      start_v[0] = 1'b1; start_v[1] = 1'b1;
      tick();
      start_v[0] = 1'b0; start_v[1] = 1'b0;
      for (int t = 0; t < 6; t++) begin
        cmp($sformatf("tbl_op%0h_t%0d", tbl[i].op, t + 1), 0, 32'(act[0]), 32'(tbl[i].m[t]));
        cmp($sformatf("tbl_op%0h_ts", tbl[i].op), 0, 32'(ts[0]), 32'(t + 1));
        tick();
      end
      cmp("rerun_t1", 0, 32'(ts[0]), 32'd1);
      cmp("step_back_idle", 1, 32'(ts[1]), 32'd0);
    end

    // HLT: halts after T4, ignores start, leaves only on reset.
    do_reset();
    op_v[0] = 4'hF; op_v[1] = 4'hF;
    start_v[0] = 1'b1; start_v[1] = 1'b1;
    tick();
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    cmp("hlt_ts", 0, 32'(ts[0]), 32'd7);
    cmp("hlt_flag", 0, 32'(hl[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      start_v[0] = i[0]; start_v[1] = i[0];
      op_v[0] = 4'h0;    op_v[1] = 4'h0;
      tick();
    end
    cmp("hlt_sticky", 0, 32'(ts[0]), 32'd7);
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    m_phase[0] = 0; m_phase[1] = 0;
    cmp("hlt_rst_ts", 0, 32'(ts[0]), 32'd0);
    cmp("hlt_rst_flag", 0, 32'(hl[0]), 32'd0);
    check_all();
    tick();
    rst_n = 1'b1;

    // Single-step: back to IDLE after T6, waits there, restarts on start.
    op_v[1] = 4'h1;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    cmp("step_idle", 1, 32'(ts[1]), 32'd0);
    tick();
    tick();
    cmp("step_wait", 1, 32'(ts[1]), 32'd0);
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    cmp("step_restart", 1, 32'(ts[1]), 32'd1);

    // Random traffic against the model; HLT is left to the directed sequence.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        start_v[k] = ($urandom_range(0, 3) == 0);
        op_v[k]    = 4'($urandom_range(0, 14));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
